// File: rtl/hdmi_src_compositor.sv
// Two-source pixel compositor: a rectangular window from one source is laid over a background
// from the other, and responses are muxed with the same latency the sources have.
module hdmi_src_compositor #(
  parameter int RESP_LATENCY = 1,
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_en,
  input  logic          req_sof,
  input  logic          req_sol,
  output logic [7:0]    resp_red,
  output logic [7:0]    resp_green,
  output logic [7:0]    resp_blue,
  output logic          a_req_en,
  output logic          a_req_sof,
  output logic          a_req_sol,
  input  logic [7:0]    a_resp_red,
  input  logic [7:0]    a_resp_green,
  input  logic [7:0]    a_resp_blue,
  output logic          b_req_en,
  output logic          b_req_sof,
  output logic          b_req_sol,
  input  logic [7:0]    b_resp_red,
  input  logic [7:0]    b_resp_green,
  input  logic [7:0]    b_resp_blue,
  input  logic          cfg_bg_sel,
  input  logic          cfg_win_en,
  input  logic [XW-1:0] cfg_win_x0,
  input  logic [XW-1:0] cfg_win_x1,
  input  logic [YW-1:0] cfg_win_y0,
  input  logic [YW-1:0] cfg_win_y1,
  output logic [7:0]    frame_cnt,
  output logic          running
);
  // state | meaning
  // IDLE  | waiting for the first sof; only a sof request is forwarded
  // RUN   | locked to the raster; every request is forwarded
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int L = RESP_LATENCY;

  state_t state, state_nxt;
  logic accept, fwd, take, in_win, sel;
  logic [XW-1:0] x_q, px;
  logic [YW-1:0] y_q, py;
  logic bg_s, win_en_s, bg_e, win_en_e;
  logic [XW-1:0] x0_s, x1_s, x0_e, x1_e;
  logic [YW-1:0] y0_s, y1_s, y0_e, y1_e;
  logic [L-1:0] sel_d, vld_d;

  assign accept = req_en & req_sof;
  // rst gates the sof path so nothing reaches the sources while reset is held
  assign fwd  = ~rst & ((state == RUN) | accept);
  assign take = req_en & fwd;

  assign a_req_en  = req_en & fwd;
  assign a_req_sof = req_sof & fwd;
  assign a_req_sol = req_sol & fwd;
  assign b_req_en  = req_en & fwd;
  assign b_req_sof = req_sof & fwd;
  assign b_req_sol = req_sol & fwd;

  assign running = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept) state_nxt = RUN;
  end

  always_comb begin
    px = (&x_q) ? x_q : x_q + XW'(1);
    if (req_sof | req_sol) px = '0;
    py = y_q;
    if (req_sof)      py = '0;
    else if (req_sol) py = (&y_q) ? y_q : y_q + YW'(1);
  end

  // the sof pixel already sees the config it loads
  assign bg_e     = accept ? cfg_bg_sel : bg_s;
  assign win_en_e = accept ? cfg_win_en : win_en_s;
  assign x0_e     = accept ? cfg_win_x0 : x0_s;
  assign x1_e     = accept ? cfg_win_x1 : x1_s;
  assign y0_e     = accept ? cfg_win_y0 : y0_s;
  assign y1_e     = accept ? cfg_win_y1 : y1_s;

  assign in_win = win_en_e & (px >= x0_e) & (px <= x1_e) & (py >= y0_e) & (py <= y1_e);
  assign sel    = in_win ? ~bg_e : bg_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      bg_s      <= 1'b0;
      win_en_s  <= 1'b0;
      x0_s      <= '0;
      x1_s      <= '0;
      y0_s      <= '0;
      y1_s      <= '0;
      sel_d     <= '0;
      vld_d     <= '0;
      frame_cnt <= '0;
    end else begin
      if (take) begin
        x_q <= px;
        y_q <= py;
      end
      if (accept) begin
        bg_s      <= cfg_bg_sel;
        win_en_s  <= cfg_win_en;
        x0_s      <= cfg_win_x0;
        x1_s      <= cfg_win_x1;
        y0_s      <= cfg_win_y0;
        y1_s      <= cfg_win_y1;
        frame_cnt <= frame_cnt + 8'd1;
      end
      sel_d[0] <= sel;
      vld_d[0] <= take;
      for (int i = 1; i < L; i++) begin
        sel_d[i] <= sel_d[i-1];
        vld_d[i] <= vld_d[i-1];
      end
    end
  end

  always_comb begin
    resp_red   = '0;
    resp_green = '0;
    resp_blue  = '0;
    if (vld_d[L-1]) begin
      if (sel_d[L-1]) begin
        resp_red   = b_resp_red;
        resp_green = b_resp_green;
        resp_blue  = b_resp_blue;
      end else begin
        resp_red   = a_resp_red;
        resp_green = a_resp_green;
        resp_blue  = a_resp_blue;
      end
    end
  end

endmodule
